// File: rtl/cim_pkg.sv
// -----------------------------------------------------------------------------
// cim_pkg
// Shared definitions for the CIM macro arbiter slice: default macro sequence
// timing, the phase counter type and a small window-decode helper.
// No ports (package).
// -----------------------------------------------------------------------------
package cim_pkg;

  localparam int SEQ_LEN_DEF  = 12;
  localparam int ADC_LO_DEF   = 5;
  localparam int ADC_HI_DEF   = 7;
  localparam int LATCH_LO_DEF = 8;

  // Wide enough for any SEQ_LEN up to 32.
  localparam int PHASE_W = 5;
  typedef logic [PHASE_W-1:0] phase_t;

  // True when lo <= p <= hi.
  function automatic logic phase_in(input phase_t p, input int lo, input int hi);
    return (int'(p) >= lo) && (int'(p) <= hi);
  endfunction

endpackage

// File: rtl/cim_macro_arbiter_if.sv
// -----------------------------------------------------------------------------
// cim_macro_arbiter_if
// Request/grant bus between the window-generator requesters and the arbiter.
//   req_valid : requester -> arbiter, one-cycle request pulses
//   grant     : one-hot macro owner
//   gnt_id    : binary owner index
//   pending   : queued-request flags
//   done      : end-of-sequence pulse, done_id = finishing owner
// master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface cim_macro_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] gnt_id;
  logic [NREQ-1:0]  pending;
  logic             done;
  logic [IDX_W-1:0] done_id;

  modport master (
    output req_valid,
    input  grant, gnt_id, pending, done, done_id
  );

  modport slave (
    input  req_valid,
    output grant, gnt_id, pending, done, done_id
  );
endinterface

// File: rtl/cim_rr_pick.sv
// -----------------------------------------------------------------------------
// cim_rr_pick
// Combinational winner pick: scans pending starting at index ptr and wrapping,
// first set bit wins. With ptr tied to 0 this is plain fixed priority.
//   pending : request flags
//   ptr     : search start index
//   winner  : one-hot winner (0 when nothing pending)
//   win_idx : binary winner index
// -----------------------------------------------------------------------------
module cim_rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  pending,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  winner,
  output logic [IDX_W-1:0] win_idx
);

  logic found;
  int   cand;

  always_comb begin
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(ptr) + i) % NREQ;
      if (!found && pending[cand]) begin
        found        = 1'b1;
        winner[cand] = 1'b1;
        win_idx      = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/cim_macro_arbiter.sv
// -----------------------------------------------------------------------------
// cim_macro_arbiter
// Shares one CIM macro between NREQ window-generator requesters. A grant owns
// the macro for phases 1..SEQ_LEN-1; enable/adc/latch strobes are decoded from
// the registered phase. Back-to-back grants leave no idle gap.
//
// Ports:
//   clk, rstn          : clock, async active-low reset
//   mode_in            : 0 = parameter load (flush), 1 = calculate
//   verticle_sync      : frame start, synchronous flush
//   bus (slave)        : req_valid / grant / gnt_id / pending / done / done_id
//   enable_to_macro    : phase != 0
//   adc_to_macro       : ADC_LO <= phase <= ADC_HI
//   latch_to_macro     : phase >= LATCH_LO
//   ovf_err            : sticky request overrun
//
// Build option: define CIM_ARB_FIXED_PRIO_EN for fixed priority (lowest
// pending index wins, no pointer register); default is round-robin.
//
// State (phase) | meaning
// 0             | idle, macro free
// 1..ADC_LO-1   | enabled, settling
// ADC_LO..ADC_HI| conversion window
// LATCH_LO..    | result latch
// SEQ_LEN-1     | last phase, done pulse, re-grant point
// -----------------------------------------------------------------------------
module cim_macro_arbiter
  import cim_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int SEQ_LEN  = SEQ_LEN_DEF,
  parameter int ADC_LO   = ADC_LO_DEF,
  parameter int ADC_HI   = ADC_HI_DEF,
  parameter int LATCH_LO = LATCH_LO_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 mode_in,
  input  logic                 verticle_sync,
  cim_macro_arbiter_if.slave   bus,
  output logic                 enable_to_macro,
  output logic                 adc_to_macro,
  output logic                 latch_to_macro,
  output logic                 ovf_err
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam phase_t PH_LAST = phase_t'(SEQ_LEN - 1);

  phase_t           phase_q,   phase_n;
  logic [NREQ-1:0]  grant_q,   grant_n;
  logic [IDX_W-1:0] gnt_id_q,  gnt_id_n;
  logic [NREQ-1:0]  pending_q, pending_n;
  logic             done_q,    done_n;
  logic [IDX_W-1:0] done_id_q, done_id_n;
  logic             ovf_q,     ovf_n;

  logic [NREQ-1:0]  winner;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] pick_ptr;
  logic [NREQ-1:0]  clr;
  logic             flush;
  logic             last_phase;
  logic             take;

`ifdef CIM_ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [IDX_W-1:0] ptr_q, ptr_n;
  assign pick_ptr = ptr_q;
`endif

  cim_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .pending (pending_q),
    .ptr     (pick_ptr),
    .winner  (winner),
    .win_idx (win_idx)
  );

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_q   <= '0;
      grant_q   <= '0;
      gnt_id_q  <= '0;
      pending_q <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      ovf_q     <= 1'b0;
`ifndef CIM_ARB_FIXED_PRIO_EN
      ptr_q     <= '0;
`endif
    end else begin
      phase_q   <= phase_n;
      grant_q   <= grant_n;
      gnt_id_q  <= gnt_id_n;
      pending_q <= pending_n;
      done_q    <= done_n;
      done_id_q <= done_id_n;
      ovf_q     <= ovf_n;
`ifndef CIM_ARB_FIXED_PRIO_EN
      ptr_q     <= ptr_n;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    flush      = ~mode_in | verticle_sync;
    last_phase = (phase_q == PH_LAST);
    take       = ((phase_q == '0) || last_phase) && (|pending_q) && !flush;
    clr        = take ? winner : '0;

    phase_n   = phase_q;
    grant_n   = grant_q;
    gnt_id_n  = gnt_id_q;
    pending_n = pending_q;
    done_n    = 1'b0;
    done_id_n = done_id_q;
    ovf_n     = ovf_q;
`ifndef CIM_ARB_FIXED_PRIO_EN
    ptr_n     = ptr_q;
`endif

    if (flush) begin
      phase_n   = '0;
      grant_n   = '0;
      gnt_id_n  = '0;
      pending_n = '0;
      ovf_n     = 1'b0;
    end else begin
      // A fresh request beats the clear caused by its own grant.
      pending_n = (pending_q & ~clr) | bus.req_valid;
      ovf_n     = ovf_q | (|(bus.req_valid & pending_q & ~clr));

      if (take) begin
        phase_n  = phase_t'(1);
        grant_n  = winner;
        gnt_id_n = win_idx;
`ifndef CIM_ARB_FIXED_PRIO_EN
        ptr_n    = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
`endif
      end else if (last_phase) begin
        phase_n  = '0;
        grant_n  = '0;
        gnt_id_n = '0;
      end else if (phase_q != '0) begin
        phase_n  = phase_q + 1'b1;
      end

      // done is registered so it sits exactly on the last phase.
      if ((phase_n == PH_LAST) && (phase_n != '0)) begin
        done_n    = 1'b1;
        done_id_n = gnt_id_n;
      end
    end
  end

  // Output decode, registered state only
  always_comb begin
    enable_to_macro = (phase_q != '0);
    adc_to_macro    = phase_in(phase_q, ADC_LO, ADC_HI);
    latch_to_macro  = phase_in(phase_q, LATCH_LO, SEQ_LEN - 1);
    ovf_err         = ovf_q;
  end

  assign bus.grant   = grant_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.pending = pending_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;

endmodule
